// File: rtl/dsp_div_seq_pkg.sv
// Shared ALU package: operation codes plus divider state encoding and defaults.
// Imported by dsp_div_seq and its restoring-step datapath.
package dsp_div_seq_pkg;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_MUL,
    ALU_MULH,
    ALU_DIV,
    ALU_DIVU,
    ALU_REM,
    ALU_REMU
  } alu_op_t;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_CALC,
    DIV_FIXUP,
    DIV_DONE
  } div_state_t;

  localparam int DIV_WIDTH_DEFAULT = 32;

  function automatic logic is_div_op(alu_op_t op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/dsp_div_seq_restore_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   acc_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // acc always stays below divisor between steps, so diff's MSB is a clean borrow.
  always_comb begin
    shifted = {acc, quo[WIDTH-1]};
    diff    = shifted - {2'b00, divisor};
    if (!diff[WIDTH+1]) begin
      acc_next = diff[WIDTH:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = shifted[WIDTH:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/dsp_div_seq.sv
// Iterative restoring divider for RV32M/RV64M DIV/DIVU/REM/REMU with kill support.
// Optional DSP_DIV_EARLY_OUT_EN skips iteration for trivially-resolved operands.
module dsp_div_seq
  import dsp_div_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             kill,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  div_state_t state, state_next;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs_mag;
  logic             is_rem;
  logic             q_neg;
  logic             r_neg;
  logic             div_zero;
  logic             sgn_ovf;

  logic [WIDTH:0]   acc_step;
  logic [WIDTH-1:0] quo_step;

  logic             accept;
  logic             op_signed;
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;
  logic             in_div_zero;
  logic             in_ovf;
  logic             early;
  logic             last_step;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  // Negating the most-negative value wraps back to itself, which is its unsigned magnitude.
  always_comb begin
    accept      = (state == DIV_IDLE) && start && !kill && is_div_op(op);
    op_signed   = (op == ALU_DIV) || (op == ALU_REM);
    dvd_neg     = op_signed && dividend[WIDTH-1];
    dvs_neg     = op_signed && divisor[WIDTH-1];
    dvd_abs     = dvd_neg ? -dividend : dividend;
    dvs_abs     = dvs_neg ? -divisor : divisor;
    in_div_zero = (divisor == '0);
    in_ovf      = op_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
`ifdef DSP_DIV_EARLY_OUT_EN
    early       = in_div_zero || in_ovf || (dvs_abs > dvd_abs);
`else
    early       = 1'b0;
`endif
    last_step   = (cnt == CNT_W'(WIDTH - 1));
  end

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .quo      (quo),
    .divisor  (dvs_mag),
    .acc_next (acc_step),
    .quo_next (quo_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= DIV_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state == DIV_CALC) || (state == DIV_FIXUP);
    done       = (state == DIV_DONE);
    case (state)
      DIV_IDLE:  if (accept) state_next = early ? DIV_FIXUP : DIV_CALC;
      DIV_CALC:  if (last_step) state_next = DIV_FIXUP;
      DIV_FIXUP: state_next = DIV_DONE;
      DIV_DONE:  state_next = DIV_IDLE;
      default:   state_next = DIV_IDLE;
    endcase
    if (kill && (state != DIV_IDLE)) state_next = DIV_IDLE;
  end

  // Early-out operands land in FIXUP with quotient 0 and the dividend as remainder.
  always_comb begin
    quo_fix = q_neg ? -quo : quo;
    rem_fix = r_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    if (div_zero) quo_fix = '1;
    if (sgn_ovf) begin
      quo_fix = {1'b1, {(WIDTH-1){1'b0}}};
      rem_fix = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      quo      <= '0;
      dvs_mag  <= '0;
      is_rem   <= 1'b0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
      sgn_ovf  <= 1'b0;
      result   <= '0;
    end else begin
      if (accept) begin
        is_rem   <= (op == ALU_REM) || (op == ALU_REMU);
        q_neg    <= dvd_neg ^ dvs_neg;
        r_neg    <= dvd_neg;
        div_zero <= in_div_zero;
        sgn_ovf  <= in_ovf;
        dvs_mag  <= dvs_abs;
        cnt      <= '0;
        if (early) begin
          acc <= {1'b0, dvd_abs};
          quo <= '0;
        end else begin
          acc <= '0;
          quo <= dvd_abs;
        end
      end else if (state == DIV_CALC) begin
        acc <= acc_step;
        quo <= quo_step;
        cnt <= cnt + 1'b1;
      end
      if ((state == DIV_FIXUP) && !kill) result <= is_rem ? rem_fix : quo_fix;
    end
  end

endmodule

// File: tb/tb_dsp_div_seq.sv
// Directed plus random scoreboard bench for dsp_div_seq (WIDTH=32).
// Expected latency follows DSP_DIV_EARLY_OUT_EN when that macro is defined.
module tb_dsp_div_seq;
  import dsp_div_seq_pkg::*;

  localparam int W = 32;
`ifdef DSP_DIV_EARLY_OUT_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          start;
  alu_op_t       op;
  logic [W-1:0]  dividend;
  logic [W-1:0]  divisor;
  logic          kill;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;

  int checkCount = 0;
  int passCount  = 0;
  int elapsed;
  int busyCycles;
  bit gotDone;
  logic [W-1:0] expQ[$];
  int           latQ[$];

  dsp_div_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .kill     (kill),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RISC-V reference semantics, special cases first so SV division never overflows.
  function automatic logic [W-1:0] modelDiv(alu_op_t o, logic [W-1:0] a, logic [W-1:0] b);
    logic sgn;
    logic isRem;
    sgn   = (o == ALU_DIV) || (o == ALU_REM);
    isRem = (o == ALU_REM) || (o == ALU_REMU);
    if (b == '0) return isRem ? a : '1;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return isRem ? '0 : 32'h8000_0000;
    if (sgn) return isRem ? W'($signed(a) % $signed(b)) : W'($signed(a) / $signed(b));
    return isRem ? a % b : a / b;
  endfunction

  function automatic int latFor(alu_op_t o, logic [W-1:0] a, logic [W-1:0] b);
    logic sgn;
    logic [W-1:0] magA;
    logic [W-1:0] magB;
    bit early;
    sgn   = (o == ALU_DIV) || (o == ALU_REM);
    magA  = (sgn && a[W-1]) ? -a : a;
    magB  = (sgn && b[W-1]) ? -b : b;
    early = (b == '0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || (magB > magA);
    return (EARLY_EN && early) ? 2 : W + 2;
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, observed, expected);
  endtask

  task automatic stepCycle();
    @(negedge clk);
    elapsed++;
    if (done) gotDone = 1'b1;
    else if (busy) busyCycles++;
  endtask

  task automatic applyStimulus(input alu_op_t o, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] expected, input bit track);
    @(negedge clk);
    op       = o;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    if (track) begin
      expQ.push_back(expected);
      latQ.push_back(latFor(o, a, b));
    end
    @(posedge clk);
    #1 start = 1'b0;
    elapsed    = 0;
    busyCycles = 0;
    gotDone    = 1'b0;
  endtask

  task automatic collectResult(input string tag);
    logic [W-1:0] expVal;
    int expLat;
    while (!gotDone && elapsed < 60) stepCycle();
    expVal = expQ.pop_front();
    expLat = latQ.pop_front();
    checkOutput({tag, "_done"}, W'(gotDone), W'(1));
    checkOutput({tag, "_result"}, result, expVal);
    checkOutput({tag, "_latency"}, W'(elapsed), W'(expLat));
    checkOutput({tag, "_busy_cycles"}, W'(busyCycles), W'(expLat - 1));
  endtask

  task automatic runOp(input string tag, input alu_op_t o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] expected);
    applyStimulus(o, a, b, expected, 1'b1);
    collectResult(tag);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; kill = 1'b0;
    op = ALU_ADD; dividend = '0; divisor = '0;
    elapsed = 0; busyCycles = 0; gotDone = 1'b0;

    #12;
    checkOutput("reset_busy", W'(busy), W'(0));
    checkOutput("reset_done", W'(done), W'(0));
    checkOutput("reset_result", result, '0);
    @(negedge clk);
    rst_n = 1'b1;

    runOp("divu_100_7", ALU_DIVU, 32'd100, 32'd7, 32'h0000_000E);
    runOp("remu_100_7", ALU_REMU, 32'd100, 32'd7, 32'd2);
    runOp("div_m7_2", ALU_DIV, -32'sd7, 32'd2, 32'hFFFF_FFFD);
    runOp("rem_m7_2", ALU_REM, -32'sd7, 32'd2, 32'hFFFF_FFFF);
    runOp("rem_7_m2", ALU_REM, 32'd7, -32'sd2, 32'd1);
    runOp("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    runOp("rem_ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    runOp("divu_5_0", ALU_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);
    runOp("remu_5_0", ALU_REMU, 32'd5, 32'd0, 32'd5);
    runOp("div_m5_0", ALU_DIV, -32'sd5, 32'd0, 32'hFFFF_FFFF);
    runOp("divu_3_10", ALU_DIVU, 32'd3, 32'd10, 32'd0);

    // kill at cycle 10 of a DIVU: busy drops next cycle, no done, result untouched
    applyStimulus(ALU_DIVU, 32'd1000, 32'd3, '0, 1'b0);
    repeat (10) stepCycle();
    kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    gotDone = 1'b0;
    stepCycle();
    checkOutput("kill_busy", W'(busy), W'(0));
    repeat (40) stepCycle();
    checkOutput("kill_no_done", W'(gotDone), W'(0));
    checkOutput("kill_result_held", result, 32'd0);
    runOp("divu_ffff_3", ALU_DIVU, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555);

    // start together with kill in IDLE is not accepted
    @(negedge clk);
    op = ALU_DIVU; dividend = 32'd9; divisor = 32'd2; start = 1'b1; kill = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; kill = 1'b0;
    @(negedge clk);
    checkOutput("kill_start_busy", W'(busy), W'(0));

    // start while busy with other operands is ignored
    applyStimulus(ALU_DIVU, 32'd50, 32'd5, 32'd10, 1'b1);
    repeat (4) stepCycle();
    op = ALU_REMU; dividend = 32'd99; divisor = 32'd9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    collectResult("start_while_busy");

    // asynchronous reset mid-CALC clears outputs immediately
    applyStimulus(ALU_DIVU, 32'd1000, 32'd7, '0, 1'b0);
    repeat (5) stepCycle();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_busy", W'(busy), W'(0));
    checkOutput("midreset_done", W'(done), W'(0));
    checkOutput("midreset_result", result, '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      alu_op_t ro;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      case ($urandom_range(3))
        0:       ro = ALU_DIV;
        1:       ro = ALU_DIVU;
        2:       ro = ALU_REM;
        default: ro = ALU_REMU;
      endcase
      ra = $urandom();
      rb = (i % 2 == 0) ? W'($urandom_range(1000) + 1) : W'($urandom());
      runOp($sformatf("rand%0d", i), ro, ra, rb, modelDiv(ro, ra, rb));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
